// File: rtl/debounce_bank.sv
// N_CH-channel pushbutton conditioner: 2-flop sync, saturating stability counter, registered level plus press/release pulses.
// Optional auto-repeat of press_p while held is enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_bank #(
    parameter int N_CH          = 4,
    parameter int STABILITY     = 130_000,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 12_600_000,
    parameter int REPEAT_PERIOD = 2_520_000
) (
    input  logic            clk25,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_out,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p
);

    localparam int CW = $clog2(STABILITY + 1);

    if (STABILITY < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_bank: STABILITY, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;
    logic [CW-1:0]   cnt [N_CH];
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] repeat_hit;

    assign lvl = (ACTIVE_LOW != 0) ? ~button_in : button_in;

    // A channel accepts once sync_b has been steady for STABILITY cycles and differs from the held level.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (cnt[i] == CW'(STABILITY)) && (sync_b[i] != button_out[i]);
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            button_out <= '0;
            press_p    <= '0;
            release_p  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_a    <= lvl;
            sync_b    <= sync_a;
            press_p   <= (accept & sync_b) | repeat_hit;
            release_p <= accept & ~sync_b;
            for (int i = 0; i < N_CH; i++) begin
                if (sync_a[i] != sync_b[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CW'(STABILITY)) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
                if (accept[i]) begin
                    button_out[i] <= sync_b[i];
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0]   hcnt [N_CH];
    logic [N_CH-1:0] rep_phase;

    // A release being accepted this edge suppresses any repeat that would coincide with it.
    always_comb begin
        repeat_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            repeat_hit[i] = button_out[i] && !accept[i] &&
                            (hcnt[i] == (rep_phase[i] ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (accept[i] && sync_b[i]) begin
                    hcnt[i]      <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (button_out[i]) begin
                    if (repeat_hit[i]) begin
                        hcnt[i]      <= '0;
                        rep_phase[i] <= 1'b1;
                    end else begin
                        hcnt[i] <= hcnt[i] + HW'(1);
                    end
                end
            end
        end
    end
`else
    assign repeat_hit = '0;
`endif

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel button conditioner: N_CH independent channels, each with a 2-flop synchroniser, stability counter and debounced level.
- Adds per-channel press/release single-cycle pulses and selectable input polarity.
- Sits between raw board pushbuttons and game/control logic in the clk25 domain.
- Replaces single-channel debouncers in the top level.

Parameters:
- N_CH, 4: number of independent channels.
- STABILITY, 130_000: cycles the synchronised input must hold before acceptance (≈5 ms at 25.2 MHz); must be ≥1.
- ACTIVE_LOW, 0: 1 = raw input low means pressed; output is always active-high "pressed".
- REPEAT_DELAY, 12_600_000: cycles held before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 2_520_000: cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk25  in  1  main clock.
- reset  in  1  synchronous, active-high reset.
- button_in  in  N_CH  raw asynchronous button levels.
- button_out  out  N_CH  debounced level, 1 = pressed.
- press_p  out  N_CH  1-cycle pulse on an accepted press (and on auto-repeat, when enabled).
- release_p  out  N_CH  1-cycle pulse on an accepted release.

Behaviour:
- Channels are fully independent; no shared state apart from clk25/reset.
- Polarity: lvl[i] = button_in[i] XOR ACTIVE_LOW (logical pressed level).
- Sync: a[i] <= lvl[i]; b[i] <= a[i].
- Counter per channel, width $clog2(STABILITY+1), so it can hold STABILITY exactly.
  - a[i] != b[i]: cnt <= 0.
  - else if cnt < STABILITY: cnt <= cnt+1.
  - cnt saturates at STABILITY; it never wraps.
- Acceptance: when cnt == STABILITY and b[i] != stable[i], stable[i] <= b[i].
  - In that same edge: press_p[i] <= b[i], release_p[i] <= ~b[i].
  - Otherwise both pulses <= 0 (except auto-repeat).
- button_out, press_p and release_p are all registered outputs.
- Latency: counting edge 1 as the first rising edge that samples the new stable level, stable[i] and the pulse update at edge STABILITY+3.
- Glitch rejection: any toggle shorter than STABILITY+1 cycles of steady b resets the counter, so it produces no output change and no pulse.
- Pulses are exactly 1 cycle wide; press_p and release_p are never high together on one channel.
- Reset (any cycle, including mid-count):
  - a, b, stable set to 0 (released).
  - cnt set to 0.
  - press_p, release_p set to 0.
  - No pulse is generated by reset itself or by its release.
  - A button already held through reset is accepted as a press STABILITY+3 edges after reset deasserts.
- Simultaneous events across channels are handled in parallel in the same cycle.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined: each channel adds a hold counter of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Counter clears on accept-press.
  - While stable[i]=1 it counts; on reaching REPEAT_DELAY it emits press_p[i] and reloads.
  - Thereafter it emits press_p[i] every REPEAT_PERIOD cycles while held.
  - Release stops repeats immediately; no repeat pulse coincides with release_p.
  - Reset clears the hold counter.
- Undefined: no hold counter; press_p fires only once per accepted press.

Test Plan:
- STABILITY=8, N_CH=4, ACTIVE_LOW=0: raise button_in[0] and hold -> button_out[0]=1 and press_p[0]=1 for exactly 1 cycle at edge 11; other channels stay 0.
- Same config: pulse button_in[1] high for 5 cycles, then low -> button_out[1] stays 0, no press_p/release_p on any channel.
- Bounce train on ch2 (toggle every 3 cycles for 30 cycles, then hold high) -> single press_p[2], 11 edges after the final transition; later drop low and hold -> single release_p[2], 11 edges after the drop.
- ACTIVE_LOW=1: button_in=4'b1111 after reset, then drive ch3 low -> button_out[3]=1 at edge 11; channels 0-2 remain 0 throughout.
- Hold ch0 pressed, assert reset for 1 cycle mid-hold -> all outputs 0 the next cycle, no pulse; press_p[0] re-fires 11 edges after reset deasserts.
- DEBOUNCE_REPEAT_EN, STABILITY=8, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold ch1 for 60 cycles -> press_p[1] at accept, +20 cycles, then every 5 cycles; release -> release_p[1] with no trailing repeat.
